// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity mode constants and baud divider helper.
package uart_pkg;

  typedef enum logic [2:0] {
    s_IDLE   = 3'd0,
    s_START  = 3'd1,
    s_DATA   = 3'd2,
    s_PARITY = 3'd3,
    s_STOP   = 3'd4
  } state_t;

  localparam logic [1:0] PARITY_NONE = 2'b00;
  localparam logic [1:0] PARITY_ODD  = 2'b01;
  localparam logic [1:0] PARITY_EVEN = 2'b10;

  // Clock cycles per line bit; integer divide, rounding toward zero.
  function automatic int bit_ticks(input int clk_mhz, input int baud);
    return (clk_mhz * 1000000) / baud;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered count; head word is presented combinationally on o_Data.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     i_Clock,
  input  logic                     i_Reset,
  input  logic                     i_Push,
  input  logic [WIDTH-1:0]         i_Data,
  input  logic                     i_Pop,
  output logic [WIDTH-1:0]         o_Data,
  output logic                     o_Full,
  output logic                     o_Empty,
  output logic [$clog2(DEPTH):0]   o_Count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             push_ok, pop_ok;

  assign o_Full  = (count == (AW+1)'(DEPTH));
  assign o_Empty = (count == '0);
  assign o_Count = count;
  assign o_Data  = mem[rd_ptr];
  // Full is judged on the registered count, so a pop never opens a slot in its own cycle.
  assign push_ok = i_Push && !o_Full && !i_Reset;
  assign pop_ok  = i_Pop && !o_Empty;

  always_ff @(posedge i_Clock) begin
    if (push_ok) mem[wr_ptr] <= i_Data;
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// Buffered UART transmitter: valid/ready byte input, 8 data bits LSB first, optional parity, 1-2 stop bits.
module uart_tx
  import uart_pkg::*;
#(
  parameter int         CLOCK_FREQ_Mhz = 12,
  parameter int         BAUD_RATE      = 9600,
  parameter logic [1:0] PARITY_MODE    = 2'b00,
  parameter int         STOP_BITS      = 1,
  parameter int         FIFO_DEPTH     = 16
) (
  input  logic                          i_Clock,
  input  logic                          i_Reset,
  input  logic [7:0]                    i_Data,
  input  logic                          i_Valid,
  output logic                          o_Ready,
  output logic                          o_Tx,
  output logic                          o_Idle,
  output logic [$clog2(FIFO_DEPTH):0]   o_FifoCount
);

  localparam int BIT_TICKS  = bit_ticks(CLOCK_FREQ_Mhz, BAUD_RATE);
  localparam int STOP_TICKS = STOP_BITS * BIT_TICKS;
  localparam int CW         = $clog2(STOP_TICKS + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_TICKS - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_TICKS - 1);
  localparam logic PAR_EN = (PARITY_MODE == PARITY_ODD) || (PARITY_MODE == PARITY_EVEN);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [7:0]    shift;
  logic [2:0]    bit_idx;
  logic          par_bit;
  logic          fifo_full, fifo_empty, pop;
  logic [7:0]    fifo_data;

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .i_Clock (i_Clock),
    .i_Reset (i_Reset),
    .i_Push  (i_Valid),
    .i_Data  (i_Data),
    .i_Pop   (pop),
    .o_Data  (fifo_data),
    .o_Full  (fifo_full),
    .o_Empty (fifo_empty),
    .o_Count (o_FifoCount)
  );

  assign o_Ready = !fifo_full;
  assign o_Idle  = (state == s_IDLE) && fifo_empty;
  // A new frame starts from idle or straight out of the last stop-bit cycle, leaving no gap.
  assign pop = !i_Reset && !fifo_empty &&
               ((state == s_IDLE) || ((state == s_STOP) && (cnt == '0)));

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state   <= s_IDLE;
      o_Tx    <= 1'b1;
      cnt     <= '0;
      shift   <= '0;
      bit_idx <= '0;
      par_bit <= 1'b0;
    end else if (pop) begin
      shift   <= fifo_data;
      par_bit <= (PARITY_MODE == PARITY_EVEN) ? ^fifo_data : ~^fifo_data;
      o_Tx    <= 1'b0;
      cnt     <= BIT_LAST;
      state   <= s_START;
    end else begin
      case (state)
        s_IDLE: o_Tx <= 1'b1;
        s_START: begin
          if (cnt == '0) begin
            o_Tx    <= shift[0];
            cnt     <= BIT_LAST;
            bit_idx <= '0;
            state   <= s_DATA;
          end else cnt <= cnt - CW'(1);
        end
        s_DATA: begin
          if (cnt == '0) begin
            if (bit_idx == 3'd7) begin
              if (PAR_EN) begin
                o_Tx  <= par_bit;
                cnt   <= BIT_LAST;
                state <= s_PARITY;
              end else begin
                o_Tx  <= 1'b1;
                cnt   <= STOP_LAST;
                state <= s_STOP;
              end
            end else begin
              shift   <= shift >> 1;
              o_Tx    <= shift[1];
              cnt     <= BIT_LAST;
              bit_idx <= bit_idx + 3'd1;
            end
          end else cnt <= cnt - CW'(1);
        end
        s_PARITY: begin
          if (cnt == '0) begin
            o_Tx  <= 1'b1;
            cnt   <= STOP_LAST;
            state <= s_STOP;
          end else cnt <= cnt - CW'(1);
        end
        s_STOP: begin
          if (cnt == '0) state <= s_IDLE;
          else cnt <= cnt - CW'(1);
        end
        default: begin
          state <= s_IDLE;
          o_Tx  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Three transmitters (no parity/1 stop, even/1 stop, odd/2 stop) at 10 cycles per bit, line decoded and scoreboarded.
module tb_uart_tx;

  localparam int BT = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam logic [1:0] PM = (g == 1) ? 2'b10 : (g == 2) ? 2'b01 : 2'b00;
    localparam int SB = (g == 2) ? 2 : 1;
    localparam int P  = (PM != 2'b00) ? 1 : 0;
    localparam int NB = 1 + 8 + P + SB;
    localparam int FL = NB * BT;

    logic       rst = 1'b1, vld = 1'b0;
    logic [7:0] din = 8'h00;
    logic       tx, rdy, idle;
    logic [4:0] cnt;
    logic       fin = 1'b0;
    int         started = 0, contig = 0, last_end = -1;
    logic [7:0] exp_q [$];

    uart_tx #(
      .CLOCK_FREQ_Mhz(1), .BAUD_RATE(100000), .PARITY_MODE(PM),
      .STOP_BITS(SB), .FIFO_DEPTH(16)
    ) dut (
      .i_Clock(clk), .i_Reset(rst), .i_Data(din), .i_Valid(vld),
      .o_Ready(rdy), .o_Tx(tx), .o_Idle(idle), .o_FifoCount(cnt)
    );

    // Scoreboard input: every accepted byte becomes one expected frame.
    always @(posedge clk) if (vld && rdy && !rst) exp_q.push_back(din);

    // Line decoder: each bit slot must hold one value for exactly BT cycles.
    initial begin : mon
      logic [NB-1:0] bits;
      logic [7:0]    e;
      int            glitch, st;
      logic          ab;
      forever begin
        @(negedge clk);
        if (rst) exp_q.delete();
        else if (tx === 1'b0) begin
          st = cyc;
          started++;
          if (st == last_end) contig++;
          glitch = 0; ab = 1'b0; bits = '0;
          for (int s = 0; s < NB && !ab; s++)
            for (int t = 0; t < BT && !ab; t++) begin
              if (s != 0 || t != 0) @(negedge clk);
              if (rst) ab = 1'b1;
              else if (t == 0) bits[s] = tx;
              else if (tx !== bits[s]) glitch++;
            end
          if (ab) exp_q.delete();
          else begin
            last_end = cyc + 1;
            if (exp_q.size() == 0) chk("spurious_frame", started, -1);
            else begin
              e = exp_q.pop_front();
              chk("start_bit", int'(bits[0]), 0);
              chk("data_byte", int'(bits[8:1]), int'(e));
              if (P == 1)
                chk("parity_bit", int'(bits[9]),
                    (PM == 2'b10) ? ($countones(e) % 2) : (1 - $countones(e) % 2));
              chk("stop_bits", int'(bits[NB-1 -: SB]), (1 << SB) - 1);
              chk("bit_stable", glitch, 0);
            end
          end
        end
      end
    end

    task automatic tick();
      @(posedge clk); #1;
    endtask

    task automatic wr(input logic [7:0] d);
      int n = 0;
      din = d; vld = 1'b1;
      while (!rdy && n < 1000) begin tick(); n++; end
      tick();
      vld = 1'b0;
    endtask

    task automatic drain();
      int n = 0;
      while (!(idle && exp_q.size() == 0) && n < 5000) begin tick(); n++; end
      chk("drain_in_time", int'(n < 5000), 1);
    endtask

    initial begin : stim
      int n, acc, c0, s0;
      logic r;
      repeat (3) tick();
      chk("reset_tx", tx, 1);
      chk("reset_ready", rdy, 1);
      chk("reset_idle", idle, 1);
      chk("reset_count", cnt, 0);
      rst = 1'b0;
      tick();

      // Single frame: start bit one edge after acceptance, idle exactly FL cycles later.
      wr((g == 0) ? 8'hA5 : 8'h07);
      chk("pre_pop_tx", tx, 1);
      tick();
      chk("latency_tx_low", tx, 0);
      n = 1;
      while (!idle && n < 1000) begin tick(); n++; end
      chk("frame_len", n, FL + 1);

      if (g == 2) begin
        c0 = contig;
        wr(8'hFF); wr(8'h3C);
        drain();
        chk("stop2_back_to_back", contig - c0, 1);
      end

      if (g == 0) begin
        // Burst with valid held: 17 accepted, FIFO then full while valid stays high.
        c0 = contig; acc = 0; n = 0;
        din = 8'h00; vld = 1'b1;
        while (acc < 17 && n < 200) begin
          r = rdy; tick(); n++;
          if (r) begin acc++; din = 8'(acc); end
        end
        chk("burst_cycles", n, 17);
        chk("full_ready", rdy, 0);
        chk("full_count", cnt, 16);
        din = 8'hEE;
        repeat (40) begin tick(); chk("hold_full_count", cnt, 16); end
        vld = 1'b0;
        drain();
        chk("burst_contig", contig - c0, 16);

        // Reset in the middle of a data bit with bytes still queued.
        wr(8'h00); wr(8'h01); wr(8'h02); wr(8'h03);
        repeat (30) tick();
        chk("mid_frame_tx", tx, 0);
        s0 = started;
        rst = 1'b1; vld = 1'b1; din = 8'h55;
        tick();
        chk("midrst_tx", tx, 1);
        chk("midrst_count", cnt, 0);
        chk("midrst_ready", rdy, 1);
        chk("midrst_idle", idle, 1);
        rst = 1'b0; vld = 1'b0;
        repeat (300) tick();
        chk("no_frames_after_rst", started - s0, 0);
        chk("count_after_rst", cnt, 0);
        chk("tx_after_rst", tx, 1);
      end

      repeat (24) begin
        n = $urandom_range(0, 3);
        repeat (n) tick();
        wr(8'($urandom));
      end
      drain();
      fin = 1'b1;
    end
  end

  initial begin : top_ctl
    int n = 0;
    while (!(g_dut[0].fin && g_dut[1].fin && g_dut[2].fin) && n < 60000) begin
      @(posedge clk);
      n++;
    end
    chk("finish_in_time", int'(n < 60000), 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
